// File: rtl/clk_disp_pkg.sv
// Shared constants for the clock display path: segment patterns, digit slots, digit count.
package clk_disp_pkg;

  localparam int NUM_DIG = 6;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every pattern.
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [2:0] IDX_SEC_L  = 3'd0;
  localparam logic [2:0] IDX_SEC_H  = 3'd1;
  localparam logic [2:0] IDX_MIN_L  = 3'd2;
  localparam logic [2:0] IDX_MIN_H  = 3'd3;
  localparam logic [2:0] IDX_HOUR_L = 3'd4;
  localparam logic [2:0] IDX_HOUR_H = 3'd5;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg_decode.sv
// BCD digit to active-low {g..a} segment pattern; out-of-range codes show a dash.
module seg_decode
  import clk_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH[6:0];
    case (bcd)
      4'd0: seg_n = SEG_0[6:0];
      4'd1: seg_n = SEG_1[6:0];
      4'd2: seg_n = SEG_2[6:0];
      4'd3: seg_n = SEG_3[6:0];
      4'd4: seg_n = SEG_4[6:0];
      4'd5: seg_n = SEG_5[6:0];
      4'd6: seg_n = SEG_6[6:0];
      4'd7: seg_n = SEG_7[6:0];
      4'd8: seg_n = SEG_8[6:0];
      4'd9: seg_n = SEG_9[6:0];
      default: seg_n = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner with per-frame snapshot, blanking gap,
// leading-zero suppression and a blinking separator dp.
module seg_scan
  import clk_disp_pkg::*;
#(
  parameter int SCAN_CYC  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  output logic [7:0] seg,
  output logic [5:0] sel
);

  localparam int CW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  logic [CW-1:0]               cnt;
  logic [2:0]                  idx;
  logic [NUM_DIG-1:0][3:0]     snap;
  logic [NUM_DIG-1:0][3:0]     din;
  logic                        slot_end, frame_end, blank, dp_on, lz_hit;
  bcd_t                        cur;
  logic [6:0]                  dig_seg;
  logic [7:0]                  seg_d;
  logic [5:0]                  sel_d;

  assign din       = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
  assign slot_end  = (cnt == CW'(SCAN_CYC - 1));
  assign frame_end = slot_end && (idx == IDX_HOUR_H);
  assign blank     = (cnt < CW'(BLANK_CYC));
  assign cur       = snap[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_HOUR_H) ? IDX_SEC_L : idx + 3'd1;
      // Capture on the last cycle of the frame so a whole frame shows one time value.
      if (frame_end) snap <= din;
    end
  end

  seg_decode u_dec (
    .bcd   (cur),
    .seg_n (dig_seg)
  );

  assign dp_on  = ((idx == IDX_HOUR_L) || (idx == IDX_MIN_L)) && snap[IDX_SEC_L][0];
  assign lz_hit = (LZ_BLANK != 0) && (idx == IDX_HOUR_H) && (cur == 4'd0);

  always_comb begin
    seg_d = SEG_OFF;
    sel_d = 6'h3F;
    if (!blank) begin
      sel_d = ~(6'd1 << idx);
      // A suppressed leading zero keeps its select asserted so duty stays uniform.
      if (!lz_hit) seg_d = {~dp_on, dig_seg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      sel <= 6'h3F;
    end else begin
      seg <= seg_d;
      sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed display scenarios plus random digit churn against a
// position-based reference model; a second instance runs with leading-zero blanking off.
module tb_seg_scan;

  localparam int S  = 8;
  localparam int B  = 2;
  localparam int FR = 6 * S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dig [6];
  logic [7:0] seg, seg_nz;
  logic [5:0] sel, sel_nz;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  logic [3:0] msnap [6];

  always #5 clk = ~clk;

  seg_scan #(.SCAN_CYC(S), .BLANK_CYC(B), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .hour_h(dig[5]), .hour_l(dig[4]), .min_h(dig[3]), .min_l(dig[2]),
    .sec_h(dig[1]), .sec_l(dig[0]),
    .seg(seg), .sel(sel)
  );

  seg_scan #(.SCAN_CYC(S), .BLANK_CYC(B), .LZ_BLANK(0)) dut_nz (
    .clk(clk), .rst_n(rst_n),
    .hour_h(dig[5]), .hour_l(dig[4]), .min_h(dig[3]), .min_l(dig[2]),
    .sec_h(dig[1]), .sec_l(dig[0]),
    .seg(seg_nz), .sel(sel_nz)
  );

  function automatic logic [7:0] dec(logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Expected {sel,seg} for the cycle at position p after reset release.
  function automatic logic [13:0] model(int p, bit lz);
    int c, d;
    logic [3:0] v;
    logic [7:0] g;
    logic [5:0] s;
    c = p % S;
    d = (p / S) % 6;
    if (c < B) return {6'h3F, 8'hFF};
    s = 6'h3F;
    s[d] = 1'b0;
    v = msnap[d];
    if (lz && d == 5 && v == 4'd0) g = 8'hFF;
    else begin
      g = dec(v);
      if ((d == 2 || d == 4) && msnap[0][0]) g[7] = 1'b0;
    end
    return {s, g};
  endfunction

  task automatic chk(string tag, logic [13:0] obs, logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed sel/seg=%h/%h expected %h/%h (pos %0d)",
             tag, obs[13:8], obs[7:0], exp[13:8], exp[7:0], pos);
    end
  endtask

  task automatic tick();
    logic [13:0] e1, e0;
    logic [3:0] ns [6];
    e1 = model(pos, 1'b1);
    e0 = model(pos, 1'b0);
    ns = msnap;
    if (pos % FR == FR - 1) for (int i = 0; i < 6; i++) ns[i] = dig[i];
    @(posedge clk);
    #1;
    chk("scan_lz", {sel, seg}, e1);
    chk("scan_nolz", {sel_nz, seg_nz}, e0);
    pos++;
    msnap = ns;
  endtask

  // Advance until outputs reflect position p, then compare against a fixed pair.
  task automatic expect_at(int p, logic [5:0] es, logic [7:0] eg, string tag);
    if (p < pos) begin
      checks++;
      errors++;
      $display("FAIL %s: position %0d already passed (now %0d)", tag, p, pos);
    end else begin
      while (pos <= p) tick();
      chk(tag, {sel, seg}, {es, eg});
    end
  endtask

  task automatic set_time(int hh, int hl, int mh, int ml, int sh, int sl);
    dig[5] = 4'(hh); dig[4] = 4'(hl); dig[3] = 4'(mh);
    dig[2] = 4'(ml); dig[1] = 4'(sh); dig[0] = 4'(sl);
  endtask

  task automatic restart();
    pos = 0;
    for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
  endtask

  initial begin
    int f;
    for (int i = 0; i < 6; i++) dig[i] = 4'($urandom_range(0, 15));
    restart();

    // Held in reset with random inputs.
    repeat (4) begin
      @(posedge clk); #1;
      chk("reset_lz", {sel, seg}, {6'h3F, 8'hFF});
      chk("reset_nolz", {sel_nz, seg_nz}, {6'h3F, 8'hFF});
      for (int i = 0; i < 6; i++) dig[i] = 4'($urandom_range(0, 15));
    end

    set_time(1, 2, 3, 4, 5, 6);
    rst_n = 1'b1;
    restart();
    expect_at(1, 6'h3F, 8'hFF, "first_blank");
    expect_at(2, 6'h3E, 8'hC0, "first_drive");

    // Frame 1 shows 12:34:56.
    expect_at(FR + 2,  6'h3E, 8'h82, "t123456_d0");
    expect_at(FR + 8,  6'h3F, 8'hFF, "t123456_gap");
    expect_at(FR + 10, 6'h3D, 8'h92, "t123456_d1");
    expect_at(FR + 18, 6'h3B, 8'h99, "t123456_d2");
    expect_at(FR + 26, 6'h37, 8'hB0, "t123456_d3");
    expect_at(FR + 34, 6'h2F, 8'hA4, "t123456_d4");
    expect_at(FR + 42, 6'h1F, 8'hF9, "t123456_d5");

    // 01:00:07: leading zero blanked, separator dp lit.
    set_time(0, 1, 0, 0, 0, 7);
    expect_at(2*FR + 18, 6'h3B, 8'h40, "t010007_d2dp");
    expect_at(2*FR + 34, 6'h2F, 8'h79, "t010007_d4dp");
    expect_at(2*FR + 42, 6'h1F, 8'hFF, "t010007_lz");
    chk("t010007_nolz", {sel_nz, seg_nz}, {6'h1F, 8'hC0});

    // Invalid min_l shows a dash, with and without dp.
    set_time(0, 1, 0, 12, 0, 7);
    expect_at(3*FR + 2,  6'h3E, 8'hF8, "inval_d0");
    expect_at(3*FR + 18, 6'h3B, 8'h3F, "inval_dash_dp");
    dig[0] = 4'd6;
    expect_at(4*FR + 18, 6'h3B, 8'hBF, "inval_dash");
    expect_at(4*FR + 26, 6'h37, 8'hC0, "inval_d3");

    // Random digit churn, including out-of-range codes, at random times.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 6; i++)
        dig[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
      repeat ($urandom_range(1, 60)) tick();
    end

    // Coherence: inputs change mid-frame at idx2; frame keeps the old snapshot.
    f = pos / FR + 2;
    set_time(0, 0, 5, 9, 5, 9);
    while (pos < f*FR + 20) tick();
    set_time(0, 1, 0, 0, 0, 0);
    expect_at(f*FR + 26,     6'h37, 8'h92, "coh_old_d3");
    expect_at(f*FR + 34,     6'h2F, 8'h40, "coh_old_d4");
    expect_at(f*FR + 42,     6'h1F, 8'hFF, "coh_old_d5");
    expect_at((f+1)*FR + 2,  6'h3E, 8'hC0, "coh_new_d0");
    expect_at((f+1)*FR + 26, 6'h37, 8'hC0, "coh_new_d3");
    expect_at((f+1)*FR + 34, 6'h2F, 8'hF9, "coh_new_d4");

    // Reset in the middle of the idx3 drive phase.
    f = pos / FR + 1;
    while (pos < f*FR + 28) tick();
    chk("pre_reset_d3", {sel, seg}, {6'h37, 8'hC0});
    rst_n = 1'b0;
    #1;
    chk("async_reset_lz", {sel, seg}, {6'h3F, 8'hFF});
    chk("async_reset_nolz", {sel_nz, seg_nz}, {6'h3F, 8'hFF});
    @(posedge clk); #1;
    chk("held_reset", {sel, seg}, {6'h3F, 8'hFF});
    rst_n = 1'b1;
    restart();
    expect_at(2,       6'h3E, 8'hC0, "rst_d0_zero");
    expect_at(34,      6'h2F, 8'hC0, "rst_d4_zero");
    expect_at(42,      6'h1F, 8'hFF, "rst_d5_lz");
    expect_at(FR + 34, 6'h2F, 8'hF9, "rst_next_d4");
    expect_at(FR + 42, 6'h1F, 8'hFF, "rst_next_d5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
